// File: rtl/csi_rx_pkg.sv
// Shared definitions for the CSI-2 receive lane byte aligner: sync byte, state encoding, offset type.
// Latency: n/a (types and constants only). Backpressure: n/a.
package csi_rx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    typedef logic [2:0] offset_t;

    // Number of bits by which a candidate differs from the sync byte.
    function automatic logic [3:0] sync_dist(input logic [7:0] cand);
        return 4'($countones(cand ^ SYNC_BYTE));
    endfunction

endpackage

// File: rtl/csi_rx_sync_search.sv
// Sync search: lowest bit offset in a 16-bit window whose 8-bit candidate is the sync byte.
// Latency: combinational. Backpressure: none. CSI_RX_SOT_ERR_TOL_EN also accepts 1-bit-error candidates.
module csi_rx_sync_search
    import csi_rx_pkg::*;
(
    input  logic [15:0] i_window,
    output logic        o_hit,
    output offset_t     o_offset,
    output logic        o_err
);

    logic    w_ex_hit;
    offset_t w_ex_off;

    // Scan high to low so the lowest matching offset is the one left standing.
    always_comb begin
        w_ex_hit = 1'b0;
        w_ex_off = '0;
        for (int o = 7; o >= 0; o--) begin
            if (sync_dist(i_window[o +: 8]) == 4'd0) begin
                w_ex_hit = 1'b1;
                w_ex_off = offset_t'(o);
            end
        end
    end

`ifdef CSI_RX_SOT_ERR_TOL_EN
    logic    w_tol_hit;
    offset_t w_tol_off;

    always_comb begin
        w_tol_hit = 1'b0;
        w_tol_off = '0;
        for (int o = 7; o >= 0; o--) begin
            if (sync_dist(i_window[o +: 8]) == 4'd1) begin
                w_tol_hit = 1'b1;
                w_tol_off = offset_t'(o);
            end
        end
    end

    // An exact match anywhere outranks a single-bit-error match at a lower offset.
    assign o_hit    = w_ex_hit | w_tol_hit;
    assign o_offset = w_ex_hit ? w_ex_off : w_tol_off;
    assign o_err    = ~w_ex_hit & w_tol_hit;
`else
    assign o_hit    = w_ex_hit;
    assign o_offset = w_ex_off;
    assign o_err    = 1'b0;
`endif

endmodule

// File: rtl/csi_rx_byte_align.sv
// Lane byte aligner: hunts for the SoT sync byte at any bit offset, then emits aligned bytes.
// Latency: lock on the sync-completing edge, first payload byte valid on the following edge.
// Backpressure: none (streaming). CSI_RX_SOT_ERR_TOL_EN enables 1-bit-error SoT lock in the search.
module csi_rx_byte_align
    import csi_rx_pkg::*;
(
    input  logic       byte_clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] deser_in,
    input  logic       wait_for_sync,
    input  logic       packet_done,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sot_found,
    output logic       sot_err
);

    align_state_t r_state;
    align_state_t w_state_nxt;
    logic [7:0]   r_prev_byte;
    offset_t      r_offset;
    logic [15:0]  w_window;
    logic         w_hit;
    logic         w_err;
    offset_t      w_hit_off;
    logic         w_lock_acq;
    logic         w_dat_en;
    logic         w_vld_nxt;
    logic [7:0]   r_data_out;
    logic         r_data_valid;
    logic         r_sot_found;
    logic         r_sot_err;

    // Bit 0 of prev_byte is the earliest bit on the lane.
    assign w_window = {deser_in, r_prev_byte};

    csi_rx_sync_search u_search (
        .i_window (w_window),
        .o_hit    (w_hit),
        .o_offset (w_hit_off),
        .o_err    (w_err)
    );

    always_ff @(posedge byte_clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (wait_for_sync) w_state_nxt = HUNT;
                HUNT: begin
                    if (!wait_for_sync) w_state_nxt = IDLE;
                    else if (w_hit)     w_state_nxt = LOCKED;
                end
                LOCKED:  if (packet_done) w_state_nxt = wait_for_sync ? HUNT : IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Valid is withheld on the edge that leaves lock, so the byte that ends a packet is not flagged.
    always_comb begin
        w_lock_acq = (r_state == HUNT) && (w_state_nxt == LOCKED);
        w_dat_en   = (r_state == LOCKED);
        w_vld_nxt  = (r_state == LOCKED) && (w_state_nxt == LOCKED);
    end

    always_ff @(posedge byte_clock) begin
        if (reset) begin
            r_prev_byte  <= 8'h00;
            r_offset     <= '0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_sot_found  <= 1'b0;
            r_sot_err    <= 1'b0;
        end else begin
            r_prev_byte  <= deser_in;
            r_data_valid <= w_vld_nxt;
            r_sot_found  <= w_lock_acq;
            r_sot_err    <= w_lock_acq & w_err;
            if (w_lock_acq) r_offset <= w_hit_off;
            if (w_dat_en)   r_data_out <= w_window[r_offset +: 8];
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign sot_found  = r_sot_found;
    assign sot_err    = r_sot_err;

endmodule
